sonar_scheduler: RTL and testbench
==================================

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 4: number of ultrasonic sensors sharing one ranging engine.
REQ-002 SHALL have parameter DIS_LEN, default 16: distance width is DIS_LEN+1 bits, matching the engine.
REQ-003 SHALL have parameter TRIG_MAX, default 600: maximum cycles trigger is held while waiting for the engine's trigger acknowledge.
REQ-004 SHALL have parameter TIMEOUT, default 1_200_000: maximum cycles waited for an echo result.
REQ-005 SHALL have parameter GUARD, default 2_500_000: idle spacing between measurements (50 ms at 20 ns/cycle).
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port enable, input, 1 bit: run scheduling while high.
REQ-009 SHALL have port sensor_mask, input, NUM_SENSORS bits: sensor i is scheduled when bit i is 1.
REQ-010 SHALL have port eng_trigger, output, 1 bit: trigger to the shared engine and the selected sensor.
REQ-011 SHALL have port sel, output, clog2(NUM_SENSORS) bits: echo/trigger mux select.
REQ-012 SHALL have port eng_trig_suc, input, 1 bit: one-cycle trigger-accepted pulse from the engine.
REQ-013 SHALL have port eng_valid, input, 1 bit: one-cycle result-valid pulse from the engine.
REQ-014 SHALL have port eng_distance, input, DIS_LEN+1 bits: echo width in cycles.
REQ-015 SHALL have ports res_valid (1), res_id (sel width), res_dist (DIS_LEN+1), res_err (2), all outputs: result record; res_err is 0=ok, 1=echo timeout, 2=trigger fault.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, PICK, TRIG, MEAS, REPORT, GUARD.
REQ-018 IDLE SHALL go to PICK when enable=1 and sensor_mask is non-zero; otherwise it SHALL remain in IDLE.
REQ-019 PICK SHALL select the next set mask bit strictly after the last served sensor, round-robin with wrap from NUM_SENSORS-1 to 0; after reset the last served sensor is NUM_SENSORS-1, so sensor 0 is searched first; PICK takes one cycle and then goes to TRIG.
REQ-020 If the mask becomes zero, PICK SHALL return to IDLE.
REQ-021 sel SHALL update only in PICK and SHALL stay stable through TRIG, MEAS, REPORT and GUARD.
REQ-022 TRIG SHALL drive eng_trigger=1, starting the cycle after PICK.
REQ-023 On eng_trig_suc, TRIG SHALL drop eng_trigger on the next cycle and go to MEAS.
REQ-024 If TRIG has held for TRIG_MAX cycles without eng_trig_suc, it SHALL go to REPORT with res_err=2 and res_dist=0.
REQ-025 MEAS SHALL keep eng_trigger=0 and count cycles.
REQ-026 On eng_valid, MEAS SHALL capture eng_distance, set err=0 and go to REPORT.
REQ-027 When the MEAS count reaches TIMEOUT, or the engine overflows without a valid, MEAS SHALL report err=1 with res_dist all-ones.
REQ-028 If eng_valid and timeout occur in the same cycle, eng_valid SHALL win.
REQ-029 REPORT SHALL assert res_valid for exactly one cycle, with res_id=sel, then go to GUARD.
REQ-030 res_id, res_dist and res_err SHALL hold their values until the next REPORT.
REQ-031 GUARD SHALL wait GUARD cycles with eng_trigger=0, then go to PICK if enable=1, else to IDLE.
REQ-032 enable deasserted mid-measurement SHALL NOT abort; the sequence completes through GUARD.
REQ-033 sensor_mask SHALL be sampled only in IDLE and PICK.
REQ-034 eng_trig_suc and eng_valid outside TRIG and MEAS respectively SHALL be ignored.
REQ-035 Cycle counters SHALL be sized for max(TIMEOUT, GUARD) and SHALL reset to 0 on every state entry.

Reset
REQ-036 rst_n low SHALL asynchronously force: state IDLE, eng_trigger=0, sel=0, res_valid=0, res_id=0, res_dist=0, res_err=0, busy=0, counters=0, last served=NUM_SENSORS-1.
REQ-037 Reset asserted mid-TRIG SHALL drop eng_trigger immediately, with no glitch on release.

Structure
REQ-038 A shared package SHALL hold the state enum, the res_err codes, and the default TRIG_MAX, TIMEOUT and GUARD constants.
REQ-039 The round-robin next-sensor search SHALL be a sub-module rr_pick (inputs mask and last; outputs next and found); the ranging engine itself is instantiated outside this block.

Verification (simulation: TRIG_MAX=600, TIMEOUT=1000, GUARD=100, NUM_SENSORS=4)
REQ-040 mask=4'b1111, engine acks after 501 cycles, valid with distance=300 -> res_valid with id=0, dist=300, err=0; next trigger on sel=1 exactly 101 cycles after REPORT.
REQ-041 mask=4'b1010 -> service order 1,3,1,3; sel never 0 or 2.
REQ-042 Engine never acks -> eng_trigger high 600 cycles, then res_err=2, res_dist=0.
REQ-043 Ack given but no valid -> res_err=1 after 1000 MEAS cycles, res_dist=17'h1FFFF; valid and timeout in the same cycle -> err=0.
REQ-044 enable dropped during MEAS -> result still reported, GUARD completes, then IDLE with busy=0; reset pulse mid-TRIG -> eng_trigger=0 within the same cycle and all outputs at reset values.

Source files
------------

// File: rtl/sonar_scheduler_pkg.sv
// Shared definitions for the sonar scheduler: FSM encoding, result error codes
// and default timing constants.
package sonar_scheduler_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_PICK   = 3'd1;
   localparam state_t ST_TRIG   = 3'd2;
   localparam state_t ST_MEAS   = 3'd3;
   localparam state_t ST_REPORT = 3'd4;
   localparam state_t ST_GUARD  = 3'd5;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_TRIG    = 2'd2;

   localparam int TRIG_MAX_DEF = 600;
   localparam int TIMEOUT_DEF  = 1_200_000;
   localparam int GUARD_DEF    = 2_500_000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sonar_scheduler_rr_pick.sv
// Round-robin search: first set mask bit strictly after 'last', wrapping at N-1.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] last,
   output logic [W-1:0] next,
   output logic         found
);

   always_comb begin
      logic [W-1:0] idx;
      idx   = '0;
      next  = last;
      found = 1'b0;
      // Walk from the farthest candidate back so the nearest set bit wins.
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(last) + k) % N);
         if (mask[idx]) begin
            next  = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sonar_scheduler.sv
// Time-multiplexes one ultrasonic ranging engine across several sensors:
// pick -> trigger -> measure -> report -> guard, round-robin over sensor_mask.
module sonar_scheduler
   import sonar_scheduler_pkg::*;
#(
   parameter int NUM_SENSORS = 4,
   parameter int DIS_LEN     = 16,
   parameter int TRIG_MAX    = TRIG_MAX_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int GUARD       = GUARD_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic [NUM_SENSORS-1:0]         sensor_mask,
   output logic                           eng_trigger,
   output logic [$clog2(NUM_SENSORS)-1:0] sel,
   input  logic                           eng_trig_suc,
   input  logic                           eng_valid,
   input  logic [DIS_LEN:0]               eng_distance,
   output logic                           res_valid,
   output logic [$clog2(NUM_SENSORS)-1:0] res_id,
   output logic [DIS_LEN:0]               res_dist,
   output logic [1:0]                     res_err,
   output logic                           busy,
   output logic [2:0]                     dbg_state
);

   localparam int SEL_W = $clog2(NUM_SENSORS);
   localparam int CNT_W = $clog2(max3(TRIG_MAX, TIMEOUT, GUARD) + 1);

   localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_MAX - 1);
   localparam logic [CNT_W-1:0] MEAS_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic               eng_trigger_q, eng_trigger_d;
   logic               res_valid_q, res_valid_d;
   logic [SEL_W-1:0]   res_id_q, res_id_d;
   logic [DIS_LEN:0]   res_dist_q, res_dist_d;
   logic [1:0]         res_err_q, res_err_d;

   logic [SEL_W-1:0]   pick_next;
   logic               pick_found;

   rr_pick #(.N(NUM_SENSORS), .W(SEL_W)) u_rr_pick (
      .mask  (sensor_mask),
      .last  (last_q),
      .next  (pick_next),
      .found (pick_found)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_d     = last_q;
      res_id_d   = res_id_q;
      res_dist_d = res_dist_q;
      res_err_d  = res_err_q;
      case (state_q)
         ST_IDLE: if (enable && |sensor_mask) state_d = ST_PICK;
         ST_PICK: begin
            if (pick_found) begin
               state_d = ST_TRIG;
               sel_d   = pick_next;
               last_d  = pick_next;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TRIG: begin
            if (eng_trig_suc) begin
               state_d = ST_MEAS;
            end else if (cnt_q == TRIG_LAST) begin
               state_d    = ST_REPORT;
               res_id_d   = sel_q;
               res_dist_d = '0;
               res_err_d  = ERR_TRIG;
            end
         end
         // No overflow input from the engine: an overflowed echo surfaces as the timeout.
         ST_MEAS: begin
            if (eng_valid) begin
               state_d    = ST_REPORT;
               res_id_d   = sel_q;
               res_dist_d = eng_distance;
               res_err_d  = ERR_OK;
            end else if (cnt_q == MEAS_LAST) begin
               state_d    = ST_REPORT;
               res_id_d   = sel_q;
               res_dist_d = '1;
               res_err_d  = ERR_TIMEOUT;
            end
         end
         ST_REPORT: state_d = ST_GUARD;
         ST_GUARD:  if (cnt_q == GUARD_LAST) state_d = enable ? ST_PICK : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + CNT_W'(1);
      // Registered from next-state so the trigger never glitches on decode.
      eng_trigger_d = (state_d == ST_TRIG);
      res_valid_d   = (state_d == ST_REPORT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         sel_q         <= '0;
         last_q        <= SEL_W'(NUM_SENSORS - 1);
         eng_trigger_q <= 1'b0;
         res_valid_q   <= 1'b0;
         res_id_q      <= '0;
         res_dist_q    <= '0;
         res_err_q     <= ERR_OK;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         last_q        <= last_d;
         eng_trigger_q <= eng_trigger_d;
         res_valid_q   <= res_valid_d;
         res_id_q      <= res_id_d;
         res_dist_q    <= res_dist_d;
         res_err_q     <= res_err_d;
      end
   end

   assign eng_trigger = eng_trigger_q;
   assign sel         = sel_q;
   assign res_valid   = res_valid_q;
   assign res_id      = res_id_q;
   assign res_dist    = res_dist_q;
   assign res_err     = res_err_q;
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with shortened timing constants.
module tb_sonar_scheduler;
   import sonar_scheduler_pkg::*;

   localparam int TRIG_MAX_P = 600;
   localparam int TIMEOUT_P  = 1000;
   localparam int GUARD_P    = 100;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [3:0]  sensor_mask;
   logic        eng_trigger;
   logic [1:0]  sel;
   logic        eng_trig_suc;
   logic        eng_valid;
   logic [16:0] eng_distance;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [16:0] res_dist;
   logic [1:0]  res_err;
   logic        busy;
   logic [2:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   sonar_scheduler #(
      .NUM_SENSORS (4),
      .DIS_LEN     (16),
      .TRIG_MAX    (TRIG_MAX_P),
      .TIMEOUT     (TIMEOUT_P),
      .GUARD       (GUARD_P)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sensor_mask  (sensor_mask),
      .eng_trigger  (eng_trigger),
      .sel          (sel),
      .eng_trig_suc (eng_trig_suc),
      .eng_valid    (eng_valid),
      .eng_distance (eng_distance),
      .res_valid    (res_valid),
      .res_id       (res_id),
      .res_dist     (res_dist),
      .res_err      (res_err),
      .busy         (busy),
      .dbg_state    (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_trig(input string tag, output int n);
      n = 0;
      while (!eng_trigger && n < 400) begin
         step();
         n++;
      end
      chk({tag, "_trig_seen"}, 32'(eng_trigger), 32'd1);
   endtask

   task automatic pulse_ack();
      eng_trig_suc = 1'b1;
      step();
      eng_trig_suc = 1'b0;
   endtask

   task automatic pulse_valid(input logic [16:0] d);
      eng_valid    = 1'b1;
      eng_distance = d;
      step();
      eng_valid    = 1'b0;
      eng_distance = '0;
   endtask

   initial begin
      int n;
      int hi;
      logic [1:0] ord [4];
      ord = '{2'd1, 2'd3, 2'd1, 2'd3};

      rst_n        = 1'b0;
      enable       = 1'b0;
      sensor_mask  = 4'b0000;
      eng_trig_suc = 1'b0;
      eng_valid    = 1'b0;
      eng_distance = '0;
      #1;
      chk("rst_trigger", 32'(eng_trigger), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res_dist", 32'(res_dist), 32'd0);
      chk("rst_res_err", 32'(res_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("idle_no_enable", 32'(dbg_state), 32'(ST_IDLE));

      // Full mask: sensor 0 first, ack after 501 trigger cycles, distance 300.
      enable      = 1'b1;
      sensor_mask = 4'b1111;
      wait_trig("t1", n);
      chk("t1_first_latency", 32'(n), 32'd2);
      chk("t1_sel0", 32'(sel), 32'd0);
      hi = 0;
      for (int i = 0; i < 500; i++) begin
         step();
         if (eng_trigger) hi++;
      end
      chk("t1_trig_held", 32'(hi), 32'd500);
      pulse_ack();
      chk("t1_trig_drop", 32'(eng_trigger), 32'd0);
      chk("t1_in_meas", 32'(dbg_state), 32'(ST_MEAS));
      pulse_valid(17'd300);
      chk("t1_res_valid", 32'(res_valid), 32'd1);
      chk("t1_res_id", 32'(res_id), 32'd0);
      chk("t1_res_dist", 32'(res_dist), 32'd300);
      chk("t1_res_err", 32'(res_err), 32'd0);
      wait_trig("t1_next", n);
      chk("t1_gap_cycles", 32'(n - 1), 32'(GUARD_P + 1));
      chk("t1_sel1", 32'(sel), 32'd1);

      // Enable dropped mid-measurement: result still reported, then guard, then idle.
      pulse_ack();
      enable = 1'b0;
      repeat (5) step();
      pulse_valid(17'd7);
      chk("en_res_valid", 32'(res_valid), 32'd1);
      chk("en_res_id", 32'(res_id), 32'd1);
      chk("en_res_dist", 32'(res_dist), 32'd7);
      repeat (GUARD_P) step();
      chk("en_guard_busy", 32'(busy), 32'd1);
      chk("en_guard_no_valid", 32'(res_valid), 32'd0);
      step();
      chk("en_idle_busy", 32'(busy), 32'd0);
      chk("en_idle_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("en_hold_dist", 32'(res_dist), 32'd7);

      // Fresh start with sparse mask: order 1,3,1,3.
      rst_n = 1'b0;
      step();
      rst_n       = 1'b1;
      sensor_mask = 4'b1010;
      enable      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_trig("rr", n);
         chk("rr_sel", 32'(sel), 32'(ord[i]));
         pulse_ack();
         pulse_valid(17'(20 + i));
         chk("rr_res_valid", 32'(res_valid), 32'd1);
         chk("rr_res_id", 32'(res_id), 32'(ord[i]));
         chk("rr_res_dist", 32'(res_dist), 32'(20 + i));
      end

      // Engine never acknowledges: trigger held TRIG_MAX cycles, trigger fault.
      wait_trig("nack", n);
      chk("nack_sel", 32'(sel), 32'd1);
      hi = 1;
      for (int i = 0; i < 700; i++) begin
         step();
         if (!eng_trigger) break;
         hi++;
      end
      chk("nack_trig_cycles", 32'(hi), 32'(TRIG_MAX_P));
      chk("nack_res_valid", 32'(res_valid), 32'd1);
      chk("nack_res_err", 32'(res_err), 32'(ERR_TRIG));
      chk("nack_res_dist", 32'(res_dist), 32'd0);
      chk("nack_res_id", 32'(res_id), 32'd1);

      // Ack but no valid: echo timeout after TIMEOUT measure cycles.
      wait_trig("tmo", n);
      chk("tmo_sel", 32'(sel), 32'd3);
      pulse_ack();
      n = 0;
      for (int i = 0; i < 1100; i++) begin
         if (res_valid) break;
         step();
         n++;
      end
      chk("tmo_meas_cycles", 32'(n), 32'(TIMEOUT_P));
      chk("tmo_res_err", 32'(res_err), 32'(ERR_TIMEOUT));
      chk("tmo_res_dist", 32'(res_dist), 32'h1FFFF);
      chk("tmo_res_id", 32'(res_id), 32'd3);

      // Valid arriving on the timeout cycle wins.
      wait_trig("tie", n);
      chk("tie_sel", 32'(sel), 32'd1);
      pulse_ack();
      repeat (TIMEOUT_P - 1) step();
      chk("tie_still_meas", 32'(dbg_state), 32'(ST_MEAS));
      pulse_valid(17'd42);
      chk("tie_res_valid", 32'(res_valid), 32'd1);
      chk("tie_res_err", 32'(res_err), 32'(ERR_OK));
      chk("tie_res_dist", 32'(res_dist), 32'd42);

      // A stray valid during guard is ignored.
      step();
      pulse_valid(17'd99);
      step();
      chk("stray_no_valid", 32'(res_valid), 32'd0);
      chk("stray_hold_dist", 32'(res_dist), 32'd42);

      // Reset pulse mid-trigger: outputs drop asynchronously.
      wait_trig("rst", n);
      chk("rst_mid_sel", 32'(sel), 32'd3);
      repeat (10) step();
      chk("rst_mid_trig_before", 32'(eng_trigger), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_trigger", 32'(eng_trigger), 32'd0);
      chk("rst_mid_sel0", 32'(sel), 32'd0);
      chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
      chk("rst_mid_res_id", 32'(res_id), 32'd0);
      chk("rst_mid_res_dist", 32'(res_dist), 32'd0);
      chk("rst_mid_res_err", 32'(res_err), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      step();
      rst_n = 1'b1;
      chk("rst_release_trig", 32'(eng_trigger), 32'd0);
      wait_trig("post_rst", n);
      chk("post_rst_latency", 32'(n), 32'd2);
      chk("post_rst_sel", 32'(sel), 32'd1);
      enable = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
